// File: rtl/id_stage_pipelined.sv
// MIPS instruction-decode stage: opcode decoder, register bank, immediate extension,
// ID/EX pipeline register and load-use stall. Optional macro ID_WB_BYPASS_EN adds write-first read bypass.
module id_stage_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_BITS  = 5,
  parameter int INM_DATA_WIDTH = 16,
  parameter int EXEC_BUS_WIDTH = 6,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      flush_in,
  input  logic [DATA_WIDTH-1:0]     pc_in,
  input  logic [31:0]               inst_in,
  input  logic                      wb_write_en,
  input  logic [REG_ADDR_BITS-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      stall_out,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     pc_out,
  output logic [DATA_WIDTH-1:0]     rs_data_out,
  output logic [DATA_WIDTH-1:0]     rt_data_out,
  output logic [REG_ADDR_BITS-1:0]  rs_addr_out,
  output logic [REG_ADDR_BITS-1:0]  rt_addr_out,
  output logic [REG_ADDR_BITS-1:0]  rd_addr_out,
  output logic [DATA_WIDTH-1:0]     inm_data_out,
  output logic [EXEC_BUS_WIDTH-1:0] execute_bus_out,
  output logic [MEM_BUS_WIDTH-1:0]  memory_bus_out,
  output logic [WB_BUS_WIDTH-1:0]   wb_bus_out
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  logic [DATA_WIDTH-1:0]     bank [2**REG_ADDR_BITS];
  logic [5:0]                opcode;
  logic [REG_ADDR_BITS-1:0]  rs_addr, rt_addr, rd_addr;
  logic [DATA_WIDTH-1:0]     rs_data, rt_data, inm_ext;
  logic [EXEC_BUS_WIDTH-1:0] exec_c;
  logic [MEM_BUS_WIDTH-1:0]  mem_c;
  logic [WB_BUS_WIDTH-1:0]   wb_c;
  logic                      zero_ext, rt_used, load_use, bubble;

  assign opcode  = inst_in[31:26];
  assign rs_addr = inst_in[25:21];
  assign rt_addr = inst_in[20:16];
  assign rd_addr = inst_in[15:11];

  always_comb begin
    exec_c   = '0;
    mem_c    = '0;
    wb_c     = '0;
    zero_ext = 1'b0;
    rt_used  = 1'b0;
    case (opcode)
      OP_RTYPE: begin exec_c = 6'b100010; wb_c = 2'b10; rt_used = 1'b1; end
      OP_LW:    begin exec_c = 6'b010000; mem_c = 3'b010; wb_c = 2'b11; end
      OP_SW:    begin exec_c = 6'b010000; mem_c = 3'b001; rt_used = 1'b1; end
      OP_BEQ:   begin exec_c = 6'b000001; mem_c = 3'b100; rt_used = 1'b1; end
      OP_ADDI:  begin exec_c = 6'b010000; wb_c = 2'b10; end
      OP_ANDI:  begin exec_c = 6'b010100; wb_c = 2'b10; zero_ext = 1'b1; end
      OP_ORI:   begin exec_c = 6'b010101; wb_c = 2'b10; zero_ext = 1'b1; end
      OP_SLTI:  begin exec_c = 6'b010110; wb_c = 2'b10; end
      default: ;
    endcase
  end

  assign inm_ext = zero_ext
    ? {{(DATA_WIDTH-INM_DATA_WIDTH){1'b0}}, inst_in[INM_DATA_WIDTH-1:0]}
    : {{(DATA_WIDTH-INM_DATA_WIDTH){inst_in[INM_DATA_WIDTH-1]}}, inst_in[INM_DATA_WIDTH-1:0]};

  always_comb begin
    rs_data = bank[rs_addr];
    rt_data = bank[rt_addr];
`ifdef ID_WB_BYPASS_EN
    if (wb_write_en && wb_addr == rs_addr) rs_data = wb_data;
    if (wb_write_en && wb_addr == rt_addr) rt_data = wb_data;
`endif
    if (rs_addr == '0) rs_data = '0;
    if (rt_addr == '0) rt_data = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_ADDR_BITS; i++) bank[i] <= '0;
    end else if (wb_write_en && wb_addr != '0) begin
      bank[wb_addr] <= wb_data;
    end
  end

  // Stall contract: stall_out=1 means upstream must hold PC and IF/ID so the same
  // instruction is presented again next cycle; ID/EX takes a bubble meanwhile.
  // A flush discards the instruction, so it never stalls.
  assign load_use = in_valid && out_valid && memory_bus_out[1] && (rt_addr_out != '0) &&
                    ((rt_addr_out == rs_addr) || ((rt_addr_out == rt_addr) && rt_used));
  assign stall_out = load_use && !flush_in;
  assign bubble    = flush_in || load_use || !in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      out_valid       <= 1'b0;
      pc_out          <= '0;
      rs_data_out     <= '0;
      rt_data_out     <= '0;
      rs_addr_out     <= '0;
      rt_addr_out     <= '0;
      rd_addr_out     <= '0;
      inm_data_out    <= '0;
      execute_bus_out <= '0;
      memory_bus_out  <= '0;
      wb_bus_out      <= '0;
    end else begin
      out_valid       <= 1'b1;
      pc_out          <= pc_in;
      rs_data_out     <= rs_data;
      rt_data_out     <= rt_data;
      rs_addr_out     <= rs_addr;
      rt_addr_out     <= rt_addr;
      rd_addr_out     <= rd_addr;
      inm_data_out    <= inm_ext;
      execute_bus_out <= exec_c;
      memory_bus_out  <= mem_c;
      wb_bus_out      <= wb_c;
    end
  end

endmodule
